// File: rtl/cpu_stack_file.sv
// Operand stack for the 5-stage stack pipeline: top/top-N reads in decode, result slots
// tracked through 3a/4a/5a, commit and bypass at 5a, hazard stall, SP restore on kill.
module cpu_stack_file #(
  parameter int DATA_W = 35,
  parameter int ADDR_W = 11,
  parameter int POP_W  = 2,
  parameter int NSEL_W = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              issue_2a,
  input  logic [POP_W-1:0]  pop_cnt_2a,
  input  logic              push_2a,
  input  logic [NSEL_W-1:0] n_sel_2a,
  input  logic              need_top_0_2a,
  input  logic              need_top_n_2a,
  input  logic              kill_4a,
  input  logic [DATA_W-1:0] wb_data_5a,
  output logic [DATA_W-1:0] st__top_0_2a,
  output logic [DATA_W-1:0] st__top_n_2a,
  output logic [ADDR_W:0]   st__sp_2a,
  output logic              stall_2a,
  output logic              st__push_5a,
  output logic [1:0]        st__err
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Signed working width: wide enough for sp - 1 - n_sel and sp - pop + push without wrap.
  localparam int SW = ADDR_W + NSEL_W + 3;
  localparam logic signed [SW-1:0] ZERO_S  = '0;
  localparam logic signed [SW-1:0] ONE_S   = SW'(1);
  localparam logic signed [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] sp;
  logic [1:0]      err;

  // Shadow stages: _p0 = 3a, _p1 = 4a, _p2 = 5a
  logic              vld_p0, vld_p1, vld_p2;
  logic              push_p0, push_p1, push_p2;
  logic [ADDR_W-1:0] slot_p0, slot_p1, slot_p2;
  logic [ADDR_W:0]   spa_p0, spa_p1;

  logic signed [SW-1:0] sp_s, rd0_s, rdn_s, sp_raw, slot_raw;
  logic [ADDR_W:0]      sp_next;
  logic                 hazard, underflow, overflow, accept;

  function automatic logic [ADDR_W:0] sat_sp(input logic signed [SW-1:0] v);
    if (v < ZERO_S)  return '0;
    if (v > DEPTH_S) return DEPTH_S[ADDR_W:0];
    return v[ADDR_W:0];
  endfunction

  function automatic logic [ADDR_W-1:0] sat_slot(input logic signed [SW-1:0] v);
    if (v < ZERO_S) return '0;
    return v[ADDR_W-1:0];
  endfunction

  function automatic logic slot_hit(input logic signed [SW-1:0] idx, input logic v,
                                    input logic p, input logic [ADDR_W-1:0] slot);
    return v && p && (idx == SW'(slot));
  endfunction

  function automatic logic [DATA_W-1:0] rd_sel(input logic signed [SW-1:0] idx,
                                               input logic byp,
                                               input logic [DATA_W-1:0] wb,
                                               input logic [DATA_W-1:0] arr);
    if (idx < ZERO_S) return '0;
    if (byp)          return wb;
    return arr;
  endfunction

  // Stage 2a: reads, hazard detection, SP arithmetic
  always_comb begin
    sp_s     = SW'(sp);
    rd0_s    = sp_s - ONE_S;
    rdn_s    = rd0_s - SW'(n_sel_2a);
    slot_raw = sp_s - SW'(pop_cnt_2a);
    sp_raw   = slot_raw + SW'(push_2a);
    sp_next  = sat_sp(sp_raw);

    st__top_0_2a = rd_sel(rd0_s, slot_hit(rd0_s, vld_p2, push_p2, slot_p2),
                          wb_data_5a, mem[rd0_s[ADDR_W-1:0]]);
    st__top_n_2a = rd_sel(rdn_s, slot_hit(rdn_s, vld_p2, push_p2, slot_p2),
                          wb_data_5a, mem[rdn_s[ADDR_W-1:0]]);

    hazard = (need_top_0_2a && (slot_hit(rd0_s, vld_p0, push_p0, slot_p0) ||
                                slot_hit(rd0_s, vld_p1, push_p1, slot_p1))) ||
             (need_top_n_2a && (slot_hit(rdn_s, vld_p0, push_p0, slot_p0) ||
                                slot_hit(rdn_s, vld_p1, push_p1, slot_p1)));

    underflow = (slot_raw < ZERO_S) ||
                (need_top_0_2a && (rd0_s < ZERO_S)) ||
                (need_top_n_2a && (rdn_s < ZERO_S));
    overflow  = sp_raw > DEPTH_S;

    stall_2a = issue_2a && hazard && !kill_4a;
    accept   = issue_2a && !stall_2a && !kill_4a;
  end

  assign st__sp_2a   = sp;
  assign st__err     = err;
  assign st__push_5a = vld_p2 && push_p2;

  // Control state: SP, sticky errors, shadow valids
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sp     <= '0;
      err    <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (kill_4a)     sp <= spa_p1;
      else if (accept) sp <= sp_next;
      err[0] <= err[0] || (accept && underflow);
      err[1] <= err[1] || (accept && overflow);
      vld_p0 <= accept;
      vld_p1 <= vld_p0 && !kill_4a;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 2a -> 3a -> 4a -> 5a shadow payload; meaningful only under vld_pN
  always_ff @(posedge clk) begin
    push_p0 <= push_2a && !overflow;
    slot_p0 <= sat_slot(slot_raw);
    spa_p0  <= sp_next;
    push_p1 <= push_p0;
    slot_p1 <= slot_p0;
    spa_p1  <= spa_p0;
    push_p2 <= push_p1;
    slot_p2 <= slot_p1;
  end

  // Stage 5a: commit
  always_ff @(posedge clk) begin
    if (st__push_5a) mem[slot_p2] <= wb_data_5a;
  end

endmodule
